led_scan_ctrl: RTL and testbench
================================

Name: led_scan_ctrl

Overview:
Scan controller and frame scheduler for the 4x4 LED matrix. It sequences the 16 LED slots with a programmable dwell time and a blanking dead-time between slots to suppress ghosting. It applies global PWM brightness within each dwell. A one-deep pending frame buffer with a valid/ready handshake lets producers such as the pdm/sine LED logic update the display tear-free at frame boundaries.

Parameters:
DWELL_CYCLES, 64, clock cycles per slot drive phase; must be a multiple of 16 and at least 16.
BLANK_CYCLES, 4, clock cycles per slot blank phase; at least 1.

Ports:
clk  input  1  system clock (48 MHz HFOSC).
rst  input  1  asynchronous, active-high reset.
frame_in  input  16  LED bitmap; bit s drives slot s.
frame_valid  input  1  producer offers frame_in.
frame_ready  output  1  pending buffer can accept a frame.
brightness  input  4  global duty level, 0..15.
aled  output  4  anode select, active-low one-cold.
kled_tri  output  4  cathode SB_IO output-enable, one-hot when lit.
slot  output  4  current slot index.
frame_start  output  1  one-cycle pulse when the active frame is swapped in.

Behaviour:
- Reset (async, immediate) values:
  - aled=4'b1111, kled_tri=4'b0000, slot=0, frame_start=0, frame_ready=1.
  - Internal state: state=BLANK, phase counter=0, active frame=0, pending empty, latched brightness=0.
- Slot mapping, same as the existing matrix wiring:
  - aled = ~(4'b0001 << slot[1:0]).
  - Cathode bit = 4'b0001 << slot[3:2].
- FSM states BLANK and DRIVE; one counter cnt:
  - BLANK: aled=1111, kled_tri=0. Hold for BLANK_CYCLES cycles (cnt 0..BLANK_CYCLES-1), then go to DRIVE with cnt=0.
  - DRIVE: aled per mapping for the whole phase. kled_tri = cathode bit when active[slot]=1 and cnt < (bright_l+1)*(DWELL_CYCLES/16); otherwise 0. Hold for DWELL_CYCLES cycles, then go to BLANK with slot=slot+1 (wraps 15->0).
  - Outputs are registered and reflect the state/cnt of the same cycle; no combinational path from inputs to aled or kled_tri.
- Frame period = 16*(BLANK_CYCLES+DWELL_CYCLES) cycles; 1088 at defaults.
- Frame boundary is the DRIVE->BLANK transition out of slot 15, i.e. the first cycle of slot 0 BLANK. On that cycle:
  - If pending is full: active <= pending, pending cleared, frame_start=1 for one cycle.
  - brightness is sampled into bright_l every boundary, whether or not a swap occurs.
  - With no pending frame, the active frame repeats and frame_start stays 0.
- Handshake:
  - frame_ready = !pending_full (registered).
  - Transfer occurs when frame_valid && frame_ready. pending <= frame_in, and ready drops the next cycle.
  - frame_in is ignored when ready=0. The producer holds valid and data until accepted.
- Simultaneous events:
  - Transfer on a boundary cycle with pending empty: the frame goes to pending and is promoted at the next boundary, one frame of latency. It is never written directly to active.
  - Boundary promotion with pending full: ready was 0 that cycle, so no transfer can coincide. Ready rises the cycle after the swap.
- Latency:
  - A frame accepted at cycle t is first visible at the first boundary after t.
  - The first lit cycle is BLANK_CYCLES cycles after that boundary.
- brightness changes mid-frame have no effect until the next boundary.
- Reset mid-scan:
  - LEDs go dark immediately.
  - Pending and active frames are discarded.
  - The scan restarts at slot 0 BLANK after rst deasserts.
- Width rules:
  - cnt is wide enough for max(BLANK_CYCLES, DWELL_CYCLES)-1.
  - On-time product is computed at full width with no truncation; brightness 15 gives a lit cycle count of DWELL_CYCLES.

Test Plan:
1. Reset release, no frames -> aled=1111 for cycles 0..3, slot increments every 68 cycles, kled_tri stays 0 for 2 frames, frame_start never pulses.
2. frame_in=16'h0001, brightness=15 pushed at cycle 10 -> accepted at cycle 10. frame_start pulses at cycle 1088. From cycle 1092, aled=1110 and kled_tri=0001 for 64 cycles, then 0 for the rest of the frame.
3. frame_in=16'h8000, brightness=0 -> in slot 15 DRIVE, aled=0111 and kled_tri=1000 for exactly 4 cycles, then 0 for 60 cycles.
4. Push frames A=16'h00FF then B=16'hFF00 back-to-back with valid held -> A accepted, ready=0 until the boundary, B accepted the cycle after frame_start. A is displayed for one full frame, then B.
5. Change brightness 15->3 mid-frame -> the lit count stays 64 until the boundary, then 16 per lit slot.
6. Assert rst during slot 9 DRIVE with LEDs lit -> the same cycle aled=1111 and kled_tri=0. After release, slot=0, frame_ready=1, and the display stays dark until a new frame is accepted and promoted.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// 4x4 LED matrix scanner: blank/drive slot sequencing, global PWM within each dwell,
// and a one-deep pending frame buffer that is swapped in only at frame boundaries.
module led_scan_ctrl #(
    parameter int DWELL_CYCLES = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  brightness,
    output logic [3:0]  aled,
    output logic [3:0]  kled_tri,
    output logic [3:0]  slot,
    output logic        frame_start
);
    localparam int CMAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    slot_q, slot_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   pend_q, pend_d;
    logic          full_q, full_d;
    logic [3:0]    bright_q, bright_d;
    logic          ready_q, fs_q, swap, xfer, lit_d;
    logic [3:0]    aled_q, aled_d, kled_q, kled_d;
    logic [31:0]   on_cycles_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        slot_d   = slot_q;
        active_d = active_q;
        pend_d   = pend_q;
        full_d   = full_q;
        bright_d = bright_q;
        swap     = 1'b0;
        xfer     = frame_valid && ready_q;
        case (state_q)
            BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                state_d = DRIVE;
                cnt_d   = '0;
            end
            DRIVE: if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                state_d = BLANK;
                cnt_d   = '0;
                slot_d  = slot_q + 4'd1;
                // Leaving slot 15 is the frame boundary: latch brightness, promote pending.
                if (slot_q == 4'd15) begin
                    bright_d = brightness;
                    if (full_q) begin
                        swap     = 1'b1;
                        active_d = pend_q;
                        full_d   = 1'b0;
                    end
                end
            end
            default: state_d = BLANK;
        endcase
        // Ready is low whenever full, so a transfer never collides with a swap.
        if (xfer) begin
            pend_d = frame_in;
            full_d = 1'b1;
        end
        on_cycles_d = ({28'd0, bright_d} + 32'd1) * 32'(DWELL_CYCLES / 16);
        lit_d       = (32'(cnt_d) < on_cycles_d);
        aled_d      = (state_d == DRIVE) ? ~(4'b0001 << slot_d[1:0]) : 4'b1111;
        kled_d      = (state_d == DRIVE && active_d[slot_d] && lit_d) ? (4'b0001 << slot_d[3:2]) : 4'b0000;
    end

    // Outputs are registered from next-state so they line up with state/cnt of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BLANK;
            cnt_q    <= '0;
            slot_q   <= '0;
            active_q <= '0;
            pend_q   <= '0;
            full_q   <= 1'b0;
            bright_q <= '0;
            ready_q  <= 1'b1;
            fs_q     <= 1'b0;
            aled_q   <= 4'b1111;
            kled_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            full_q   <= full_d;
            bright_q <= bright_d;
            ready_q  <= !full_d && !swap;
            fs_q     <= swap;
            aled_q   <= aled_d;
            kled_q   <= kled_d;
        end
    end

    assign frame_ready = ready_q;
    assign frame_start = fs_q;
    assign aled        = aled_q;
    assign kled_tri    = kled_q;
    assign slot        = slot_q;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: directed scenarios plus random traffic, every cycle compared
// against a frame-position model derived from the cycle count since reset release.
module tb_led_scan_ctrl;
    localparam int DWELL = 64;
    localparam int BLANK = 4;
    localparam int SLOTC = DWELL + BLANK;
    localparam int FRAME = 16 * SLOTC;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  brightness;
    logic [3:0]  aled;
    logic [3:0]  kled_tri;
    logic [3:0]  slot;
    logic        frame_start;

    led_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .brightness(brightness), .aled(aled),
        .kled_tri(kled_tri), .slot(slot), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t;
    logic [15:0] act_m, pend_m;
    logic [3:0]  bl_m;
    bit          full_m, rdy_m, fs_m, acc_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, t);
        end
    endtask

    task automatic reset_model();
        t = 0; act_m = '0; pend_m = '0; bl_m = '0;
        full_m = 0; rdy_m = 1; fs_m = 0; acc_m = 0;
    endtask

    // Expected outputs follow from where cycle t falls in the frame.
    task automatic check();
        int pos, s, w;
        logic [3:0] ea, ek;
        pos = t % FRAME; s = pos / SLOTC; w = pos % SLOTC;
        ea = 4'hF; ek = 4'h0;
        if (w >= BLANK) begin
            ea = ~(4'(1) << (s % 4));
            if (act_m[s] && (w - BLANK) < (int'(bl_m) + 1) * (DWELL / 16))
                ek = 4'(1) << (s / 4);
        end
        chk("aled", 16'(aled), 16'(ea));
        chk("kled_tri", 16'(kled_tri), 16'(ek));
        chk("slot", 16'(slot), 16'(s));
        chk("frame_start", 16'(frame_start), 16'(fs_m));
        chk("frame_ready", 16'(frame_ready), 16'(rdy_m));
    endtask

    // Apply what happens at the end of cycle t given the inputs currently driven.
    task automatic model_step();
        bit bnd, xfer, swp;
        bnd  = ((t % FRAME) == FRAME - 1);
        xfer = frame_valid && rdy_m;
        swp  = bnd && full_m;
        if (swp) begin act_m = pend_m; full_m = 0; end
        if (xfer) begin pend_m = frame_in; full_m = 1; end
        if (bnd) bl_m = brightness;
        fs_m  = swp;
        rdy_m = !full_m && !swp;
        acc_m = xfer;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        t++;
        check();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [15:0] d);
        int n = 0;
        frame_in = d; frame_valid = 1'b1;
        do begin tick(); n++; end while (!acc_m && n < 3 * FRAME);
        if (!acc_m) chk("push_timeout", 16'(0), 16'(1));
        frame_valid = 1'b0;
    endtask

    task automatic run_to(input int pos);
        int n = 0;
        while ((t % FRAME) != pos && n < 2 * FRAME) begin tick(); n++; end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_aled", 16'(aled), 16'hF);
        chk("rst_kled", 16'(kled_tri), 16'h0);
        chk("rst_slot", 16'(slot), 16'h0);
        chk("rst_ready", 16'(frame_ready), 16'h1);
        chk("rst_fs", 16'(frame_start), 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reset_model();
        check();
    endtask

    initial begin
        rst = 1'b1; frame_in = '0; frame_valid = 1'b0; brightness = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reset_model();
        check();
        // Idle scan: dark, no frame_start.
        run(2 * FRAME);
        // Single LED slot 0 at full brightness.
        do_reset();
        run(9);
        brightness = 4'd15;
        push(16'h0001);
        run(2 * FRAME);
        // Slot 15 at minimum brightness.
        brightness = 4'd0;
        push(16'h8000);
        run(2 * FRAME);
        // Back-to-back frames with valid held.
        brightness = 4'd7;
        push(16'h00FF);
        push(16'hFF00);
        run(2 * FRAME);
        // Brightness change mid-frame applies only at the boundary.
        brightness = 4'd15;
        push(16'hFFFF);
        run_to(FRAME - 1);
        run(FRAME / 2);
        brightness = 4'd3;
        run(FRAME + FRAME / 2);
        // Reset while slot 9 is lit.
        brightness = 4'd15;
        push(16'hFFFF);
        run(FRAME);
        run_to(9 * SLOTC + BLANK + 10);
        chk("pre_rst_lit", 16'(kled_tri), 16'h4);
        do_reset();
        run(FRAME + 10);
        // Random producer traffic and brightness changes.
        repeat (6 * FRAME) begin
            if ($urandom_range(0, 99) < 2) brightness = 4'($urandom);
            frame_valid = ($urandom_range(0, 199) == 0);
            frame_in    = 16'($urandom);
            tick();
        end
        frame_valid = 1'b0;
        run(FRAME);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
